// File: rtl/tt_sweep_checker.sv
// Exhaustive input sweep and truth-table capture for an N_IN-input combinational function.
// Optional build macro STOP_ON_FAIL_EN: end the sweep on the first mismatching vector.
module tt_sweep_checker #(
  parameter int                      N_IN        = 4,
  parameter int                      HOLD_CYCLES = 10,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED    = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       f_in,
  output logic [N_IN-1:0]            vec,
  output logic                       busy,
  output logic                       done,
  output logic [(1<<N_IN)-1:0]       captured,
  output logic [N_IN:0]              mismatch_cnt,
  output logic [N_IN-1:0]            fail_vec,
  output logic                       pass
);

  localparam int NV     = 1 << N_IN;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NV-1:0]       captured_q, captured_d;
  logic [N_IN:0]       mcnt_q, mcnt_d;
  logic [N_IN-1:0]     fail_q, fail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                miss;
  logic                stop_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      captured_q <= '0;
      mcnt_q     <= '0;
      fail_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      hold_q     <= hold_d;
      captured_q <= captured_d;
      mcnt_q     <= mcnt_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    captured_d = captured_q;
    mcnt_d     = mcnt_q;
    fail_d     = fail_q;
    busy_d     = busy_q;
    done_d     = done_q;
    miss       = 1'b0;
    stop_now   = 1'b0;

    case (state_q)
      // Results from a finished sweep survive until a new start clears them.
      IDLE, FINISH: begin
        if (start) begin
          state_d    = APPLY;
          vec_d      = '0;
          hold_d     = '0;
          captured_d = '0;
          mcnt_d     = '0;
          fail_d     = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      APPLY: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          captured_d[vec_q] = f_in;
          miss = (f_in != EXPECTED[vec_q]);
          if (miss) begin
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q == '0) fail_d = vec_q;
          end
`ifdef STOP_ON_FAIL_EN
          stop_now = miss;
`else
          stop_now = 1'b0;
`endif
          hold_d = '0;
          // Last vector (or early stop) leaves vec parked on the final index.
          if (vec_q == '1 || stop_now) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec          = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign captured     = captured_q;
  assign mismatch_cnt = mcnt_q;
  assign fail_vec     = fail_q;
  assign pass         = done_q && (mcnt_q == '0);

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Self-running stimulus and capture stage for a 4-input combinational lab function.
- Drives each input vector to the function under test in turn, from 0 to 2^N_IN-1, and holds each vector for a programmable number of cycles.
- Samples the function output once per vector, builds the captured truth table and compares it bit-for-bit with an expected table.
- Sits directly upstream of the function (drives a,b,c,d) and directly downstream of it (consumes f), replacing a hand-written exhaustive testbench sequence.

Parameters:
- N_IN, 4: number of function inputs. Sweep length is NV = 2^N_IN vectors.
- HOLD_CYCLES, 10: cycles each vector is held. Legal range is 1 or more.
- EXPECTED, 16'h0000: expected truth table, NV bits wide. Bit i is the expected f for vector i.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset. Asynchronous, active-high.
- start, input, 1: level-sampled request to begin a sweep.
- f_in, input, 1: output of the function under test.
- vec, output, N_IN: current input vector. vec[N_IN-1] drives a and vec[0] drives d.
- busy, output, 1: high while a sweep is in progress.
- done, output, 1: high from sweep completion until the next accepted start.
- captured, output, NV: sampled truth table. Bit i holds f_in for vector i.
- mismatch_cnt, output, N_IN+1: number of vectors where f_in differed from EXPECTED.
- fail_vec, output, N_IN: index of the first mismatching vector. Meaningful only when mismatch_cnt is nonzero.
- pass, output, 1: equals done AND (mismatch_cnt == 0).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sweep):
  - State goes to IDLE.
  - vec, busy, done, captured, mismatch_cnt, fail_vec and pass all become 0.
  - The internal hold counter becomes 0.
- States: IDLE, APPLY, FINISH.
- IDLE:
  - On start=1 at a clock edge: go to APPLY, with vec=0, hold_cnt=0, captured=0, mismatch_cnt=0, fail_vec=0, done=0 and busy=1.
- APPLY:
  - vec is held stable. hold_cnt increments by 1 each cycle.
  - On the edge where hold_cnt==HOLD_CYCLES-1 (the sample edge):
    - captured[vec] <= f_in.
    - If f_in != EXPECTED[vec]: increment mismatch_cnt. If mismatch_cnt was 0, also set fail_vec <= vec.
    - If vec==NV-1, go to FINISH. Otherwise vec <= vec+1 and hold_cnt <= 0.
  - Each vector is therefore presented for exactly HOLD_CYCLES cycles, with no gap cycles between vectors.
  - HOLD_CYCLES=1 samples on every edge.
- FINISH:
  - busy=0 and done=1. vec holds at NV-1.
  - Results hold until the next accepted start.
  - On start=1: restart exactly as from IDLE, clearing all results in the same edge.
- Timing:
  - With start accepted at edge k, vector i is driven during cycles k+1+i*HOLD_CYCLES through k+(i+1)*HOLD_CYCLES.
  - done rises at edge k+NV*HOLD_CYCLES.
- start while busy=1 is ignored, with no restart and no effect on results.
- mismatch_cnt saturation is not needed: its width holds NV exactly.
- f_in is sampled only on sample edges. Glitches on f_in between vector changes are ignored by construction.
- vec, busy and done come directly from registers and are glitch-free.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- When defined: on the first sample edge with a mismatch, the block records the result as normal and goes to FINISH immediately.
  - vec stays at the failing index.
  - Bits of captured above fail_vec stay 0.
  - mismatch_cnt is then 1.
- When undefined: the full NV-vector sweep always runs and mismatch_cnt counts every mismatch.

Test Plan:
- Parity, full match: EXPECTED=16'h6996, HOLD=10, f_in=a^b^c^d, start pulsed for 1 cycle.
  - busy is high for 160 cycles and done rises 160 cycles after start.
  - captured=16'h6996, mismatch_cnt=0, pass=1.
- Stuck-at-0 output: EXPECTED=16'h6996, f_in=0, macro off.
  - captured=16'h0000, mismatch_cnt=8, fail_vec=1, pass=0.
- Start while busy: pulse start again at cycle 37 of the sweep.
  - No restart; done still rises at cycle 160.
  - Results are identical to the parity scenario.
- Reset mid-sweep: assert rst asynchronously while vec=5.
  - All outputs read 0 immediately.
  - A subsequent start yields a clean sweep with captured=16'h6996.
- Back-to-back minimum hold: HOLD=1, f_in=a&b&c&d, EXPECTED=16'h8000.
  - vec changes every cycle and done rises 16 cycles after start.
  - captured=16'h8000, pass=1.
- STOP_ON_FAIL_EN defined: EXPECTED=16'h6996, f_in=0.
  - done rises 20 cycles after start.
  - vec=1, fail_vec=1, mismatch_cnt=1, captured=16'h0000.
